// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester APB master arbiter.
//   apb_state_e : APB master phase (IDLE / SETUP / ACCESS)
//   DEF_*       : default address width, data width and PREADY timeout
//   WAIT_W      : width of the ACCESS wait-state counter
package apb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned DEF_ADDR_W  = 8;
  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TIMEOUT = 16;
  localparam int unsigned WAIT_W      = 8;

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin selector.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : request vector, one bit per requester
//   advance    : the current grant was taken; remember it as last granted
//   grant      : one-hot winner (all zero when nothing is requested)
module apb_rr_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  // Index of the requester granted most recently; reset to 1 so that
  // requester 0 wins the first contended round.
  logic last;

  always_comb begin
    grant = '0;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 1'b1;
    end else if (advance && (grant != '0)) begin
      last <= grant[1];
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port between two requesters.
//   PCLK, PRESETn         : clock, asynchronous active-low reset
//   req_valid/req_ready   : per-requester command handshake (ready pulses
//                           for one cycle in the accept cycle)
//   req_write/addr/wdata  : per-requester command; requester i uses slice i
//   rsp_valid             : one-cycle completion pulse to the owner
//   rsp_rdata, rsp_err    : read data (0 for writes/timeouts), error flag
//   PSEL..PWDATA          : APB master request
//   PRDATA/PREADY/PSLVERR : APB slave response
module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEF_ADDR_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                PCLK,
  input  logic                PRESETn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [2*DATA_W-1:0] req_wdata,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                PSEL,
  output logic                PENABLE,
  output logic                PWRITE,
  output logic [ADDR_W-1:0]   PADDR,
  output logic [DATA_W-1:0]   PWDATA,
  input  logic [DATA_W-1:0]   PRDATA,
  input  logic                PREADY,
  input  logic                PSLVERR
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  apb_state_e        state, state_next;
  logic [WAIT_W-1:0] wait_cnt;
  logic              armed;
  logic              owner;
  logic              accept, complete, timeout;
  logic [1:0]        grant;
  logic              sel;

  apb_rr_arbiter u_rr (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req_valid),
    .advance (accept),
    .grant   (grant)
  );

  assign sel = grant[1];

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && (req_valid != '0)) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: state_next = ACCESS;
      ACCESS: begin
        // PREADY takes priority over an expiring wait counter.
        if (PREADY) begin
          complete   = 1'b1;
          state_next = IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the state register so that an asynchronous reset drops
  // the bus request immediately.
  assign PSEL      = (state == SETUP) || (state == ACCESS);
  assign PENABLE   = (state == ACCESS);
  assign req_ready = accept ? grant : '0;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= IDLE;
      armed     <= 1'b0;
      wait_cnt  <= '0;
      owner     <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= '0;
      PWDATA    <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      // Keeps req_ready low until the first clock after reset release.
      armed <= 1'b1;

      if (state == SETUP) begin
        wait_cnt <= '0;
      end else if ((state == ACCESS) && !PREADY) begin
        wait_cnt <= wait_cnt + 1'b1;
      end

      if (accept) begin
        owner  <= sel;
        PWRITE <= sel ? req_write[1] : req_write[0];
        PADDR  <= sel ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        PWDATA <= sel ? req_wdata[2*DATA_W-1:DATA_W] : req_wdata[DATA_W-1:0];
      end

      if (complete || timeout) begin
        rsp_valid <= owner ? 2'b10 : 2'b01;
      end else begin
        rsp_valid <= '0;
      end
      rsp_err   <= timeout || (complete && PSLVERR);
      rsp_rdata <= (complete && !PWRITE) ? PRDATA : '0;
    end
  end

endmodule

// File: doc/apb_master_arbiter.md
APB_MASTER_ARBITER -- requirements
Module: apb_master_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: APB address width.
REQ-002 SHALL have parameter DATA_W, default 32: APB data width.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles to wait for PREADY, range 1..255.
REQ-004 SHALL have port PCLK, in, 1: the single clock.
REQ-005 SHALL have port PRESETn, in, 1: asynchronous, active-low reset.
REQ-006 SHALL have ports req_valid and req_ready, each in/out, 2: per-requester command handshake.
REQ-007 SHALL have port req_write, in, 2: per-requester direction, 1 = write.
REQ-008 SHALL have port req_addr, in, 2*ADDR_W: per-requester address; requester i uses slice i.
REQ-009 SHALL have port req_wdata, in, 2*DATA_W: per-requester write data; requester i uses slice i.
REQ-010 SHALL have port rsp_valid, out, 2: one-cycle completion pulse to the granted requester.
REQ-011 SHALL have port rsp_rdata, out, DATA_W: read data, shared by both requesters.
REQ-012 SHALL have port rsp_err, out, 1: completion error, meaning PSLVERR or timeout.
REQ-013 SHALL have ports PSEL, PENABLE and PWRITE, out, 1 each: APB master control.
REQ-014 SHALL have ports PADDR, out, ADDR_W, and PWDATA, out, DATA_W: APB master address and write data.
REQ-015 SHALL have ports PRDATA, in, DATA_W; PREADY, in, 1; PSLVERR, in, 1: APB slave response.

Function
REQ-016 SHALL share one APB bus between two requesters through an FSM with states IDLE, SETUP and ACCESS.
REQ-017 In IDLE with any req_valid set, SHALL select a winner, pulse req_ready[winner] for that cycle, latch the winner's write/addr/wdata, and go to SETUP.
REQ-018 Arbitration SHALL be round-robin: on simultaneous requests, the requester not granted last wins; after reset, requester 0 wins first.
REQ-019 A requester SHALL hold req_valid and its command stable until it sees req_ready; the block SHALL NOT sample an unselected requester.
REQ-020 In SETUP, SHALL drive PSEL=1, PENABLE=0 and the latched PADDR/PWRITE/PWDATA, then go to ACCESS unconditionally on the next cycle.
REQ-021 In ACCESS, SHALL drive PSEL=1, PENABLE=1 and hold PADDR/PWRITE/PWDATA stable.
REQ-022 In ACCESS with PREADY=1, SHALL go to IDLE and, on the next cycle, pulse rsp_valid[winner] with rsp_err=PSLVERR and rsp_rdata=PRDATA for reads or 0 for writes.
REQ-023 Minimum latency SHALL be: accept at cycle T, SETUP at T+1, ACCESS at T+2, rsp_valid at T+3 with zero wait states; a new accept is allowed at T+3.
REQ-024 An 8-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle with PREADY=0.
REQ-025 When the wait counter reaches TIMEOUT, SHALL leave ACCESS, deassert PSEL/PENABLE, and pulse rsp_valid[winner] with rsp_err=1 and rsp_rdata=0.
REQ-026 If PREADY=1 arrives on the timeout cycle, SHALL treat the transfer as a normal completion, not a timeout.
REQ-027 Outside SETUP/ACCESS, SHALL drive PSEL=0, PENABLE=0 and hold PADDR/PWRITE/PWDATA at their last value.
REQ-028 SHALL NOT assert rsp_valid for both requesters in the same cycle, nor more than once per accepted command.

Reset
REQ-029 While PRESETn=0, SHALL hold state=IDLE; PSEL, PENABLE, PWRITE, PADDR, PWDATA, req_ready, rsp_valid, rsp_rdata, rsp_err and the wait counter at 0; and the round-robin pointer at requester 1 as last granted.
REQ-030 Reset asserted mid-transfer SHALL drop PSEL/PENABLE immediately (asynchronously) and discard the transfer, producing no rsp_valid.

Structure
REQ-031 Package apb_arb_pkg SHALL hold the state enum (IDLE, SETUP, ACCESS) and the default ADDR_W/DATA_W/TIMEOUT constants.
REQ-032 Two-way round-robin selection SHALL be a sub-module apb_rr_arbiter (inputs req[1:0] and advance; output grant[1:0] one-hot).

Verification
REQ-033 Single write, req0 addr=0x10, wdata=0xDEADBEEF, PREADY=1 -> PSEL rises at T+1, PENABLE at T+2, rsp_valid[0] at T+3 with rsp_err=0.
REQ-034 Read, req1 addr=0x24, slave PRDATA=0x12345678 after 3 wait states -> rsp_valid[1] at T+6 with rsp_rdata=0x12345678.
REQ-035 Both requesters request continuously for 4 transfers -> grant order 0,1,0,1; no overlapping PSEL cycles.
REQ-036 Slave never asserts PREADY, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1 and rsp_rdata=0, after which PSEL=0.
REQ-037 PSLVERR=1 with PREADY on a write -> rsp_err=1 and the arbiter accepts the next request normally.
REQ-038 PRESETn low during ACCESS -> PSEL=0 at once, no rsp_valid; after release, requester 0 wins simultaneous requests.
